// File: rtl/light_pattern_decoder.sv
// light_pattern_decoder
//    Watches a stream of 3-bit string-light frames and works out which
//    lighting mode produced them: calm, right-to-left or left-to-right.
//    A mode is reported once LOCK_COUNT consecutive frame-to-frame
//    transitions agree on the same class. Illegal frames and illegal
//    transitions between legal frames raise a one-cycle error pulse.
//
// Ports
//    clk          system clock, all state updates on posedge
//    reset        asynchronous, active-high, clears all state
//    frame        LED frame, bit2 = leftmost LED
//    frame_valid  frame sampled on posedge when high
//    mode         00 none, 01 calm, 10 right-to-left, 11 left-to-right
//    locked       high while mode is valid
//    mode_change  one-cycle pulse when mode becomes a different nonzero value
//    error        one-cycle pulse on an illegal frame or illegal transition
module light_pattern_decoder #(
   parameter int unsigned LOCK_COUNT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] frame,
   input  logic       frame_valid,
   output logic [1:0] mode,
   output logic       locked,
   output logic       mode_change,
   output logic       error
);

   localparam int unsigned SW = $clog2(LOCK_COUNT + 1);
   localparam logic [SW-1:0] LOCK_MAX = SW'(LOCK_COUNT);
   localparam logic [SW-1:0] STREAK_ONE = SW'(1);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_TRACK,
      ST_LOCKED
   } state_t;

   // Class encoding doubles as the mode output encoding.
   typedef enum logic [1:0] {
      CL_NONE = 2'b00,
      CL_CALM = 2'b01,
      CL_R2L  = 2'b10,
      CL_L2R  = 2'b11
   } cls_t;

   state_t        state_q, state_d;
   logic [2:0]    prev_frame_q, prev_frame_d;
   cls_t          cand_q, cand_d;
   logic [SW-1:0] streak_q, streak_d;
   cls_t          mode_q, mode_d;
   logic          locked_q, locked_d;
   logic          mode_change_q, mode_change_d;
   logic          error_q, error_d;

   logic          frame_legal;
   logic          frame_repeat;
   cls_t          trans_cls;
   logic [SW-1:0] streak_next;

   always_comb begin
      frame_legal  = frame inside {3'b101, 3'b010, 3'b100, 3'b001};
      frame_repeat = (frame == prev_frame_q);
      case ({prev_frame_q, frame})
         6'b101_010, 6'b010_101:             trans_cls = CL_CALM;
         6'b001_010, 6'b010_100, 6'b100_001: trans_cls = CL_R2L;
         6'b100_010, 6'b010_001, 6'b001_100: trans_cls = CL_L2R;
         default:                            trans_cls = CL_NONE;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      prev_frame_d  = prev_frame_q;
      cand_d        = cand_q;
      streak_d      = streak_q;
      mode_d        = mode_q;
      locked_d      = locked_q;
      mode_change_d = 1'b0;
      error_d       = 1'b0;
      streak_next   = streak_q;

      if (frame_valid) begin
         if (!frame_legal) begin
            // prev_frame deliberately kept: EMPTY overwrites it on the next legal frame.
            error_d  = 1'b1;
            state_d  = ST_EMPTY;
            cand_d   = CL_NONE;
            streak_d = '0;
            mode_d   = CL_NONE;
            locked_d = 1'b0;
         end else begin
            case (state_q)
               ST_EMPTY: begin
                  prev_frame_d = frame;
                  state_d      = ST_TRACK;
                  cand_d       = CL_NONE;
                  streak_d     = '0;
               end
               ST_TRACK, ST_LOCKED: begin
                  if (frame_repeat) begin
                     // repeats leave everything untouched
                  end else if (trans_cls == CL_NONE) begin
                     error_d      = 1'b1;
                     prev_frame_d = frame;
                     state_d      = ST_TRACK;
                     cand_d       = CL_NONE;
                     streak_d     = '0;
                     mode_d       = CL_NONE;
                     locked_d     = 1'b0;
                  end else begin
                     prev_frame_d = frame;
                     if (state_q == ST_LOCKED && trans_cls == cand_q) begin
                        // same class while locked: streak already saturated
                     end else begin
                        // A class change while locked restarts the streak at one,
                        // which relocks at once when LOCK_COUNT is 1.
                        if (state_q == ST_TRACK && trans_cls == cand_q)
                           streak_next = streak_q + STREAK_ONE;
                        else
                           streak_next = STREAK_ONE;
                        streak_d = streak_next;
                        cand_d   = trans_cls;
                        if (streak_next == LOCK_MAX) begin
                           state_d       = ST_LOCKED;
                           mode_d        = trans_cls;
                           locked_d      = 1'b1;
                           mode_change_d = 1'b1;
                        end else begin
                           state_d  = ST_TRACK;
                           mode_d   = CL_NONE;
                           locked_d = 1'b0;
                        end
                     end
                  end
               end
               default: begin
                  state_d = ST_EMPTY;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_EMPTY;
         prev_frame_q  <= '0;
         cand_q        <= CL_NONE;
         streak_q      <= '0;
         mode_q        <= CL_NONE;
         locked_q      <= 1'b0;
         mode_change_q <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev_frame_q  <= prev_frame_d;
         cand_q        <= cand_d;
         streak_q      <= streak_d;
         mode_q        <= mode_d;
         locked_q      <= locked_d;
         mode_change_q <= mode_change_d;
         error_q       <= error_d;
      end
   end

   assign mode        = mode_q;
   assign locked      = locked_q;
   assign mode_change = mode_change_q;
   assign error       = error_q;

endmodule
